mem_responder: RTL and testbench
================================

# mem_responder

Bus-side responder for the CPU memory controller: it accepts single-word read/write requests on the controller's bus port, stalls the requester via `bus_full` for a fixed access latency, then completes the access against an internal word-addressed RAM and pulses `ack`. It sits between the memory controller's bus outputs and the backing data/instruction store, replacing an ideal zero-latency memory in simulation and on FPGA.

## Interface
- `DEPTH_WORDS`, default 256: RAM depth in 32-bit words; power of two, ≥4.
- `LATENCY`, default 2: number of BUSY cycles per access; must be ≥1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `address_in`  in  32  byte address from the controller.
- `data_in`  in  32  write data from the controller.
- `sel`  in  4  byte enables for writes; bit i enables byte i (bits 8i+7:8i).
- `read_req`  in  1  read request; level, held by requester until `ack`.
- `write_req`  in  1  write request; level, held by requester until `ack`.
- `bus_full`  out  1  responder busy; requester must hold request and not change it.
- `data_out`  out  32  read data to the controller.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle error flag, coincident with `ack`.

## Operation
- States: IDLE, BUSY, RESPOND.
- IDLE: if `read_req` or `write_req` at a rising edge, latch `address_in`, `data_in`, `sel`, op; load latency counter with LATENCY-1; go BUSY. Otherwise stay.
- Both requests high: read wins (same precedence as the controller); write is not performed.
- BUSY: counter decrements each cycle; at counter = 0 go RESPOND. Write commits to RAM on the BUSY→RESPOND edge; read data is registered into `data_out` on the same edge.
- RESPOND: `ack`=1 for exactly one cycle; unconditional return to IDLE.
- Requests in BUSY/RESPOND are ignored (not queued); a request still held in IDLE is a new access.
- Word index = `address_in[log2(DEPTH_WORDS)+1:2]`.
- Error: `address_in[1:0]` ≠ 0 or any bit above the index range set. Error access still takes full latency; `err`=1 with `ack`; no RAM write; `data_out` loaded with 0.
- Write with `sel`=0: legal, no byte changes, no error.
- `data_out` holds the last read (or error) value between reads; writes do not change it.
- RAM contents are not reset.

## Timing
- Reset values: `bus_full`=0, `data_out`=0, `ack`=0, `err`=0, state IDLE, counter 0.
- Request sampled at edge k → `bus_full`=1 from k through k+LATENCY → `ack`/`err` high in cycle after edge k+LATENCY, `bus_full`=0 in that cycle.
- Access-to-access: minimum LATENCY+2 cycles (RESPOND→IDLE→accept).
- `bus_full` is registered (decoded from state, high only in BUSY).
- Reset asserted mid-access: immediate return to IDLE, all outputs to reset values; a write not yet at the BUSY→RESPOND edge is not committed.
- Read-after-write to the same address returns the new data (write committed before the later read samples RAM).

## Structure
- Package `mem_responder_pkg`: `resp_state_t` enum (IDLE=0, BUSY=1, RESPOND=2), `WORD_BYTES`=4 constant.
- Sub-module `resp_sram`: DEPTH_WORDS×32 array, synchronous write with 4-bit byte enables, synchronous read; FSM, counter, latches and error decode remain in `mem_responder`.

## Test plan
- Reset: hold `rst`=0 two cycles with `read_req`=1 → `bus_full`=0, `ack`=0, `data_out`=0, state IDLE.
- Write then read: write `address_in`=0x10, `data_in`=0xDEADBEEF, `sel`=4'hF; `bus_full` high 2 cycles, `ack` pulse; then read 0x10 → `ack` with `data_out`=0xDEADBEEF, `err`=0.
- Byte enables: over 0xDEADBEEF at 0x10 write 0x000000AA with `sel`=4'b0001 → read 0x10 gives 0xDEADBEAA.
- Precedence: `read_req`=`write_req`=1 at 0x10, `data_in`=0x12345678 → read completes with 0xDEADBEAA; subsequent read still 0xDEADBEAA.
- Errors: read 0x11 → `ack`=`err`=1, `data_out`=0; write 0x400 (DEPTH 256) → `err`=1, read 0x0 unchanged.
- Reset mid-write: write 0x20=0xCAFEF00D, assert `rst` in first BUSY cycle → outputs reset; read 0x20 does not return 0xCAFEF00D (pre-loaded 0).

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared types and constants for the memory responder slice.
//   resp_state_t : responder FSM encoding (IDLE=0, BUSY=1, RESPOND=2)
//   WORD_BYTES   : bytes per RAM word (one byte enable per byte)
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } resp_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/resp_sram.sv
// resp_sram
//   DEPTH_WORDS x 32-bit word RAM with per-byte write enables.
//   Write and read are both synchronous to clk; contents are not reset.
// Ports:
//   clk   : clock, rising edge
//   we    : write enable (qualified by be)
//   be    : byte enables, bit i covers bits 8i+7:8i
//   waddr : write word index
//   wdata : write data
//   raddr : read word index, sampled every rising edge
//   rdata : registered read data (mem[raddr] as of the previous edge)
module resp_sram
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [AW-1:0]         waddr,
  input  logic [31:0]           wdata,
  input  logic [AW-1:0]         raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Bus-side responder for the CPU memory controller. Accepts one
//   read or write request, holds the requester off with bus_full for
//   LATENCY cycles, then completes the access against resp_sram and
//   pulses ack (with err for misaligned / out-of-range addresses).
//
// Handshake: read_req/write_req are levels held by the requester until
//   it sees ack. A request is accepted on any rising edge where the
//   responder is IDLE; while bus_full is high the requester must not
//   change the request. ack (and err) are single-cycle pulses in the
//   RESPOND cycle; requests seen in BUSY/RESPOND are dropped, and a
//   request still held once back in IDLE starts a new access.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   address_in : byte address
//   data_in    : write data
//   sel        : write byte enables
//   read_req   : read request (wins if both requests are high)
//   write_req  : write request
//   bus_full   : busy, high only in BUSY
//   data_out   : last read data (0 after an error access)
//   ack        : completion pulse
//   err        : error pulse, coincident with ack
//   dbg_state  : current FSM state, for observation only
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           address_in,
  input  logic [31:0]           data_in,
  input  logic [WORD_BYTES-1:0] sel,
  input  logic                  read_req,
  input  logic                  write_req,
  output logic                  bus_full,
  output logic [31:0]           data_out,
  output logic                  ack,
  output logic                  err,
  output resp_state_t           dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  resp_state_t           state;
  logic [CW-1:0]         cnt;
  logic [AW-1:0]         addr_q;
  logic [31:0]           wdata_q;
  logic [WORD_BYTES-1:0] sel_q;
  logic                  is_write_q;
  logic                  err_q;

  logic                  addr_err;
  logic [AW-1:0]         req_idx;
  logic [AW-1:0]         ram_raddr;
  logic [31:0]           ram_rdata;
  logic                  commit;
  logic                  ram_we;

  // Misaligned, or any address bit above the word-index range set.
  always_comb begin
    addr_err = 1'b0;
    if (address_in[1:0] != 2'b00) addr_err = 1'b1;
    if ((address_in >> (AW + 2)) != 32'd0) addr_err = 1'b1;
  end

  assign req_idx = address_in[AW+1:2];

  // In IDLE the RAM already looks at the incoming address so that even
  // with LATENCY=1 the registered read data is valid on the commit edge.
  assign ram_raddr = (state == IDLE) ? req_idx : addr_q;

  assign commit    = (state == BUSY) && (cnt == '0);
  assign ram_we    = commit && is_write_q && !err_q;
  assign dbg_state = state;

  resp_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk   (clk),
    .we    (ram_we),
    .be    (sel_q),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      bus_full   <= 1'b0;
      data_out   <= '0;
      ack        <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read_req || write_req) begin
            addr_q     <= req_idx;
            wdata_q    <= data_in;
            sel_q      <= sel;
            is_write_q <= !read_req;
            err_q      <= addr_err;
            cnt        <= CW'(LATENCY - 1);
            bus_full   <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            bus_full <= 1'b0;
            ack      <= 1'b1;
            err      <= err_q;
            if (err_q)            data_out <= '0;
            else if (!is_write_q) data_out <= ram_rdata;
            state    <= RESPOND;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESPOND: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          bus_full <= 1'b0;
          ack      <= 1'b0;
          err      <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address_in;
  logic [31:0] data_in;
  logic [3:0]  sel;
  logic        read_req;
  logic        write_req;
  logic        bus_full;
  logic [31:0] data_out;
  logic        ack;
  logic        err;
  resp_state_t dbg_state;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .address_in (address_in),
    .data_in    (data_in),
    .sel        (sel),
    .read_req   (read_req),
    .write_req  (write_req),
    .bus_full   (bus_full),
    .data_out   (data_out),
    .ack        (ack),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One complete access. Expected data_out is taken from exp_q.
  task automatic txn(input string tag, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wdat,
                     input logic [3:0] be, input logic exp_err);
    int          busy;
    logic        got_ack;
    logic        got_err;
    logic        full_at_ack;
    logic [31:0] got_data;
    logic [31:0] exp_data;
    busy        = 0;
    got_ack     = 1'b0;
    got_err     = 1'b0;
    full_at_ack = 1'b1;
    got_data    = '0;
    @(negedge clk);
    address_in = addr;
    data_in    = wdat;
    sel        = be;
    read_req   = rd;
    write_req  = wr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        got_ack     = 1'b1;
        got_err     = err;
        got_data    = data_out;
        full_at_ack = bus_full;
        break;
      end
      if (bus_full === 1'b1) busy++;
    end
    read_req  = 1'b0;
    write_req = 1'b0;
    check({tag, ".ack_seen"}, 32'(got_ack), 32'd1);
    check({tag, ".busy_cycles"}, 32'(busy), 32'(LAT));
    check({tag, ".full_at_ack"}, 32'(full_at_ack), 32'd0);
    check({tag, ".err"}, 32'(got_err), 32'(exp_err));
    exp_data = exp_q.pop_front();
    check({tag, ".data_out"}, got_data, exp_data);
    @(negedge clk);
    check({tag, ".ack_width"}, 32'(ack), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b0;
    address_in = '0;
    data_in    = '0;
    sel        = '0;
    read_req   = 1'b1;
    write_req  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.bus_full", 32'(bus_full), 32'd0);
    check("rst.ack", 32'(ack), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.data_out", data_out, 32'd0);
    check("rst.state", 32'(dbg_state), 32'(IDLE));
    read_req = 1'b0;
    rst      = 1'b1;
    @(negedge clk);

    exp_q.push_back(32'h0000_0000);
    txn("wr0", 1'b0, 1'b1, 32'h0, 32'h1122_3344, 4'hF, 1'b0);
    exp_q.push_back(32'h0000_0000);
    txn("wr10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    exp_q.push_back(32'hDEAD_BEEF);
    txn("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

    // byte lane 0 only
    exp_q.push_back(32'hDEAD_BEEF);
    txn("wr10_b0", 1'b0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 1'b0);
    exp_q.push_back(32'hDEAD_BEAA);
    txn("rd10_b0", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

    // read beats write when both are requested
    exp_q.push_back(32'hDEAD_BEAA);
    txn("both10", 1'b1, 1'b1, 32'h10, 32'h1234_5678, 4'hF, 1'b0);
    exp_q.push_back(32'hDEAD_BEAA);
    txn("rd10_after_both", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

    // sel = 0 write changes nothing and is not an error
    exp_q.push_back(32'hDEAD_BEAA);
    txn("wr10_sel0", 1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 1'b0);
    exp_q.push_back(32'hDEAD_BEAA);
    txn("rd10_after_sel0", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

    // misaligned read, out-of-range write (would alias word 0)
    exp_q.push_back(32'h0000_0000);
    txn("rd11_err", 1'b1, 1'b0, 32'h11, 32'h0, 4'h0, 1'b1);
    exp_q.push_back(32'h0000_0000);
    txn("wr400_err", 1'b0, 1'b1, 32'h400, 32'h5555_5555, 4'hF, 1'b1);
    exp_q.push_back(32'h1122_3344);
    txn("rd0_after_err", 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    // known contents at 0x20 before the aborted write
    exp_q.push_back(32'h1122_3344);
    txn("wr20_zero", 1'b0, 1'b1, 32'h20, 32'h0, 4'hF, 1'b0);

    // reset during the first BUSY cycle of a write
    @(negedge clk);
    address_in = 32'h20;
    data_in    = 32'hCAFE_F00D;
    sel        = 4'hF;
    write_req  = 1'b1;
    @(negedge clk);
    check("abort.busy_before", 32'(bus_full), 32'd1);
    rst = 1'b0;
    #1;
    check("abort.bus_full", 32'(bus_full), 32'd0);
    check("abort.ack", 32'(ack), 32'd0);
    check("abort.err", 32'(err), 32'd0);
    check("abort.data_out", data_out, 32'd0);
    check("abort.state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    write_req = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h0000_0000);
    txn("rd20_after_abort", 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
